// File: rtl/lsu_ram_master.sv
// Load/store initiator for the byte-addressed data RAM. It handles one request at a time:
// IDLE accepts and checks the request, ACCESS drives the RAM ports, and RESP holds the result.
module lsu_ram_master #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_wea,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wea_q, wea_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  fault_q, fault_d;
  logic                  req_fault;
  logic [3:0]            lane_mask;

  // Reject illegal codes, stores with unsigned widths, misalignment and addresses beyond the RAM.
  always_comb begin
    req_fault = 1'b0;
    case (req_funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = req_addr[0];
      3'b010:  req_fault = |req_addr[1:0];
      3'b100:  req_fault = req_we;
      3'b101:  req_fault = req_we | req_addr[0];
      default: req_fault = 1'b1;
    endcase
    if ((req_addr >> ADDR_WIDTH) != 32'd0) begin
      req_fault = 1'b1;
    end
  end

  always_comb begin
    lane_mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // The write enable defaults to zero, so it is asserted only for the single ACCESS cycle.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wea_d    = 4'b0000;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          rdata_d  = 32'd0;
          fault_d  = req_fault;
          if (req_fault) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            raddr_d = req_addr[ADDR_WIDTH-1:0];
            waddr_d = req_addr[ADDR_WIDTH-1:0];
            if (req_we) begin
              wdata_d = req_wdata;
              wea_d   = lane_mask;
            end
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) begin
          case (funct3_q)
            3'b000:  rdata_d = {{24{ram_rdata[7]}}, ram_rdata[7:0]};
            3'b100:  rdata_d = {24'd0, ram_rdata[7:0]};
            3'b001:  rdata_d = {{16{ram_rdata[15]}}, ram_rdata[15:0]};
            3'b101:  rdata_d = {16'd0, ram_rdata[15:0]};
            default: rdata_d = ram_rdata;
          endcase
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= 32'd0;
      wea_q    <= 4'b0000;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wea_q    <= wea_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign ram_raddr  = raddr_q;
  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign ram_wea    = wea_q;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a falling-edge RAM model.
// Expected responses are queued at request time and compared when the response appears.
module tb_lsu_ram_master;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [AW-1:0] ram_raddr;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wea;
  logic [31:0]   ram_rdata;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   passed_checks = 0;
  int   total_checks = 0;
  int   wea_cycles = 0;

  lsu_ram_master #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .ram_raddr  (ram_raddr),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_wea    (ram_wea),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Byte-addressed RAM: registered read and byte-lane write, both on the falling edge.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_wea[i]) mem[ram_waddr + AW'(i)] <= ram_wdata[8*i +: 8];
    end
    ram_rdata <= {mem[ram_raddr + AW'(3)], mem[ram_raddr + AW'(2)],
                  mem[ram_raddr + AW'(1)], mem[ram_raddr]};
    if (ram_wea != 4'b0000) wea_cycles <= wea_cycles + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents a request from posedge+1, queues its expected response and returns just after the accept edge.
  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input string tag,
                                input logic [31:0] exp_rdata, input logic exp_fault);
    int n = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_output({tag, "_accept_bound"}, 32'(n < 20), 32'd1);
    sb.push_back('{tag, exp_rdata, exp_fault});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic check_resp(input int hold, input int exp_lat);
    int          lat = 1;
    logic [31:0] held;
    exp_t        e;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      check_output("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check_output({e.tag, "_latency"}, 32'(lat), 32'(exp_lat));
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output({e.tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check_output({e.tag, "_hold_rdata"}, resp_rdata, held);
      check_output({e.tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    check_output({e.tag, "_rdata"}, resp_rdata, e.rdata);
    check_output({e.tag, "_fault"}, 32'(resp_fault), 32'(e.fault));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check_output({e.tag, "_idle_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic fault_case(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input string tag);
    int            w0 = wea_cycles;
    logic [AW-1:0] a0 = ram_waddr;
    apply_stimulus(we, f3, addr, 32'hA5A5A5A5, tag, 32'd0, 1'b1);
    check_output({tag, "_wea"}, 32'(ram_wea), 32'd0);
    check_resp(0, 1);
    check_output({tag, "_no_write"}, 32'(wea_cycles), 32'(w0));
    check_output({tag, "_waddr_held"}, 32'(ram_waddr), 32'(a0));
  endtask

  initial begin
    int w0;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst_resp_rdata", resp_rdata, 32'd0);
    check_output("rst_resp_fault", 32'(resp_fault), 32'd0);
    check_output("rst_wea", 32'(ram_wea), 32'd0);
    check_output("rst_raddr", 32'(ram_raddr), 32'd0);
    check_output("rst_waddr", 32'(ram_waddr), 32'd0);
    check_output("rst_wdata", ram_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    w0 = wea_cycles;
    apply_stimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, "sw_100", 32'd0, 1'b0);
    check_output("sw_100_wea", 32'(ram_wea), 32'hF);
    check_output("sw_100_waddr", 32'(ram_waddr), 32'h100);
    check_output("sw_100_wdata", ram_wdata, 32'hDEADBEEF);
    check_resp(0, 2);
    check_output("sw_100_wea_cycles", 32'(wea_cycles - w0), 32'd1);
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'd0, "lw_100", 32'hDEADBEEF, 1'b0);
    check_output("lw_100_wea", 32'(ram_wea), 32'd0);
    check_output("lw_100_raddr", 32'(ram_raddr), 32'h100);
    check_resp(0, 2);

    apply_stimulus(1'b1, 3'b010, 32'h200, 32'h01FF7F80, "sw_200", 32'd0, 1'b0);
    check_resp(0, 2);
    apply_stimulus(1'b0, 3'b000, 32'h200, 32'd0, "lb_200", 32'hFFFFFF80, 1'b0);
    check_resp(0, 2);
    apply_stimulus(1'b0, 3'b100, 32'h200, 32'd0, "lbu_200", 32'h00000080, 1'b0);
    check_resp(0, 2);
    apply_stimulus(1'b0, 3'b001, 32'h202, 32'd0, "lh_202", 32'h000001FF, 1'b0);
    check_resp(0, 2);
    apply_stimulus(1'b0, 3'b101, 32'h200, 32'd0, "lhu_200", 32'h00007F80, 1'b0);
    check_resp(0, 2);

    apply_stimulus(1'b1, 3'b010, 32'h300, 32'h11223344, "sw_300", 32'd0, 1'b0);
    check_resp(0, 2);
    apply_stimulus(1'b1, 3'b000, 32'h301, 32'h123456AB, "sb_301", 32'd0, 1'b0);
    check_output("sb_301_wea", 32'(ram_wea), 32'h1);
    check_output("sb_301_waddr", 32'(ram_waddr), 32'h301);
    check_resp(0, 2);
    apply_stimulus(1'b0, 3'b010, 32'h300, 32'd0, "lw_300", 32'h1122AB44, 1'b0);
    check_resp(0, 2);

    fault_case(1'b0, 3'b010, 32'h102, "lw_102_misaligned");
    fault_case(1'b1, 3'b001, 32'h103, "sh_103_misaligned");
    fault_case(1'b0, 3'b010, 32'h00020000, "lw_out_of_range");
    fault_case(1'b1, 3'b100, 32'h100, "store_f3_100");
    fault_case(1'b0, 3'b011, 32'h100, "load_f3_011");

    // A competing request stays pending while the response is back-pressured.
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'd0, "lw_backpressure", 32'hDEADBEEF, 1'b0);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    req_wdata  = 32'h0BADF00D;
    check_resp(5, 2);
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'd0, "lw_after_bp", 32'hDEADBEEF, 1'b0);
    check_resp(0, 2);

    w0 = wea_cycles;
    apply_stimulus(1'b1, 3'b010, 32'h100, 32'h55555555, "sw_reset", 32'd0, 1'b0);
    check_output("sw_reset_wea_before", 32'(ram_wea), 32'hF);
    rst_n = 1'b0;
    #1;
    check_output("midrst_wea", 32'(ram_wea), 32'd0);
    check_output("midrst_req_ready", 32'(req_ready), 32'd1);
    check_output("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check_output("midrst_waddr", 32'(ram_waddr), 32'd0);
    check_output("midrst_wdata", ram_wdata, 32'd0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("midrst_no_write", 32'(wea_cycles), 32'(w0));
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'd0, "lw_after_reset", 32'hDEADBEEF, 1'b0);
    check_resp(0, 2);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
